// File: rtl/shared_ll_fifo.sv
// Shared-pool multi-channel FIFO: NUM_FIFOS queues built as linked lists over one DEPTH-entry buffer.
// Optional per-channel quota enabled by defining LL_FIFO_QUOTA_EN.
module shared_ll_fifo #(
  parameter  int WIDTH     = 8,
  parameter  int DEPTH     = 8,
  parameter  int NUM_FIFOS = 4,
  parameter  int QUOTA     = DEPTH / 2,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int SEL_W     = $clog2(NUM_FIFOS),
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [SEL_W-1:0]           push_sel,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       pop,
  input  logic [SEL_W-1:0]           pop_sel,
  output logic [NUM_FIFOS-1:0]       full,
  output logic [NUM_FIFOS-1:0]       empty,
  output logic [NUM_FIFOS*CNT_W-1:0] count,
  output logic [CNT_W-1:0]           free_count,
  output logic [WIDTH-1:0]           data_out,
  output logic                       data_out_vld,
  output logic [SEL_W-1:0]           data_out_sel,
  output logic                       ovf,
  output logic                       udf
);

`ifdef LL_FIFO_QUOTA_EN
  localparam bit QUOTA_ON = 1'b1;
`else
  localparam bit QUOTA_ON = 1'b0;
`endif
  // Without the quota a channel is only limited by the pool itself.
  localparam int              CH_LIMIT = QUOTA_ON ? QUOTA : DEPTH;
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(CH_LIMIT);

  logic [WIDTH-1:0] r_mem  [DEPTH];
  logic [PTR_W-1:0] r_next [DEPTH];
  logic [PTR_W-1:0] r_head [NUM_FIFOS];
  logic [PTR_W-1:0] r_tail [NUM_FIFOS];
  logic [CNT_W-1:0] r_cnt  [NUM_FIFOS];
  logic [PTR_W-1:0] r_fhead;
  logic [PTR_W-1:0] r_ftail;
  logic [CNT_W-1:0] r_free_cnt;
  logic [WIDTH-1:0] r_dout;
  logic             r_dvld;
  logic [SEL_W-1:0] r_dsel;
  logic             r_ovf;
  logic             r_udf;

  logic [NUM_FIFOS-1:0]       w_full;
  logic [NUM_FIFOS-1:0]       w_empty;
  logic [NUM_FIFOS*CNT_W-1:0] w_count;
  logic                       w_push_sel_ok;
  logic                       w_pop_sel_ok;
  logic                       w_push_ok;
  logic                       w_pop_ok;
  logic [PTR_W-1:0]           w_wr_ptr;
  logic [PTR_W-1:0]           w_rd_ptr;
  logic                       w_free_rem_zero;
  logic                       w_same_single;

  generate
    if (NUM_FIFOS == (1 << SEL_W)) begin : g_sel_pow2
      assign w_push_sel_ok = 1'b1;
      assign w_pop_sel_ok  = 1'b1;
    end else begin : g_sel_chk
      localparam logic [SEL_W:0] NF = (SEL_W + 1)'(NUM_FIFOS);
      assign w_push_sel_ok = ({1'b0, push_sel} < NF);
      assign w_pop_sel_ok  = ({1'b0, pop_sel} < NF);
    end
  endgenerate

  always_comb begin
    w_full  = '0;
    w_empty = '0;
    w_count = '0;
    for (int c = 0; c < NUM_FIFOS; c++) begin
      w_empty[c]                = (r_cnt[c] == '0);
      w_full[c]                 = (r_free_cnt == '0) | (r_cnt[c] == LIMIT);
      w_count[c*CNT_W +: CNT_W] = r_cnt[c];
    end
  end

  // Handshake: push/pop are single-cycle requests with no wait state. A request is
  // accepted when push & ~full[push_sel] (pop & ~empty[pop_sel]) on pre-edge state;
  // a refused request is dropped and recorded in the sticky ovf/udf flag.
  assign w_push_ok = push & w_push_sel_ok & ~w_full[push_sel];
  assign w_pop_ok  = pop & w_pop_sel_ok & ~w_empty[pop_sel];
  assign w_wr_ptr  = r_fhead;
  assign w_rd_ptr  = r_head[pop_sel];

  // Free list is empty after this edge's push, so a freed entry starts a fresh list.
  assign w_free_rem_zero = w_push_ok ? (r_free_cnt == CNT_W'(1)) : (r_free_cnt == '0);
  assign w_same_single   = w_push_ok & w_pop_ok & (push_sel == pop_sel) &
                           (r_cnt[pop_sel] == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[w_wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_next[i] <= PTR_W'((i + 1) % DEPTH);
      for (int c = 0; c < NUM_FIFOS; c++) begin
        r_head[c] <= '0;
        r_tail[c] <= '0;
        r_cnt[c]  <= '0;
      end
      r_fhead    <= '0;
      r_ftail    <= PTR_W'(DEPTH - 1);
      r_free_cnt <= CNT_W'(DEPTH);
      r_dout     <= '0;
      r_dvld     <= 1'b0;
      r_dsel     <= '0;
      r_ovf      <= 1'b0;
      r_udf      <= 1'b0;
    end else begin
      r_dvld <= w_pop_ok;
      if (w_pop_ok) begin
        r_dout <= r_mem[w_rd_ptr];
        r_dsel <= pop_sel;
      end
      if (push && !w_push_ok) r_ovf <= 1'b1;
      if (pop && !w_pop_ok)   r_udf <= 1'b1;

      if (w_push_ok) begin
        if (r_cnt[push_sel] == '0) r_head[push_sel] <= w_wr_ptr;
        else                       r_next[r_tail[push_sel]] <= w_wr_ptr;
        r_tail[push_sel] <= w_wr_ptr;
        r_fhead          <= r_next[r_fhead];
      end

      if (w_pop_ok) begin
        // A lone entry popped while the same channel is pushed: the new entry is the head.
        r_head[pop_sel] <= w_same_single ? w_wr_ptr : r_next[w_rd_ptr];
        if (w_free_rem_zero) begin
          r_fhead <= w_rd_ptr;
          r_ftail <= w_rd_ptr;
        end else begin
          r_next[r_ftail] <= w_rd_ptr;
          r_ftail         <= w_rd_ptr;
        end
      end

      for (int c = 0; c < NUM_FIFOS; c++) begin
        if (w_push_ok && push_sel == SEL_W'(c) && !(w_pop_ok && pop_sel == SEL_W'(c)))
          r_cnt[c] <= r_cnt[c] + CNT_W'(1);
        else if (w_pop_ok && pop_sel == SEL_W'(c) && !(w_push_ok && push_sel == SEL_W'(c)))
          r_cnt[c] <= r_cnt[c] - CNT_W'(1);
      end

      if (w_push_ok && !w_pop_ok)      r_free_cnt <= r_free_cnt - CNT_W'(1);
      else if (w_pop_ok && !w_push_ok) r_free_cnt <= r_free_cnt + CNT_W'(1);
    end
  end

  assign full         = w_full;
  assign empty        = w_empty;
  assign count        = w_count;
  assign free_count   = r_free_cnt;
  assign data_out     = r_dout;
  assign data_out_vld = r_dvld;
  assign data_out_sel = r_dsel;
  assign ovf          = r_ovf;
  assign udf          = r_udf;

endmodule

// File: tb/tb_shared_ll_fifo.sv
// Bench for shared_ll_fifo: per-channel queue model, every-cycle compare, directed plus random traffic.
module tb_shared_ll_fifo;
  localparam int WIDTH     = 8;
  localparam int DEPTH     = 8;
  localparam int NUM_FIFOS = 4;
  localparam int QUOTA     = DEPTH / 2;
  localparam int SEL_W     = $clog2(NUM_FIFOS);
  localparam int CNT_W     = $clog2(DEPTH + 1);
`ifdef LL_FIFO_QUOTA_EN
  localparam bit QUOTA_ON = 1'b1;
`else
  localparam bit QUOTA_ON = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                       push = 1'b0;
  logic [SEL_W-1:0]           push_sel = '0;
  logic [WIDTH-1:0]           data_in = '0;
  logic                       pop = 1'b0;
  logic [SEL_W-1:0]           pop_sel = '0;
  logic [NUM_FIFOS-1:0]       full;
  logic [NUM_FIFOS-1:0]       empty;
  logic [NUM_FIFOS*CNT_W-1:0] count;
  logic [CNT_W-1:0]           free_count;
  logic [WIDTH-1:0]           data_out;
  logic                       data_out_vld;
  logic [SEL_W-1:0]           data_out_sel;
  logic                       ovf;
  logic                       udf;

  shared_ll_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_FIFOS(NUM_FIFOS), .QUOTA(QUOTA)) dut (
    .clk(clk), .rst(rst),
    .push(push), .push_sel(push_sel), .data_in(data_in),
    .pop(pop), .pop_sel(pop_sel),
    .full(full), .empty(empty), .count(count), .free_count(free_count),
    .data_out(data_out), .data_out_vld(data_out_vld), .data_out_sel(data_out_sel),
    .ovf(ovf), .udf(udf)
  );

  // behavioural model: one plain queue per channel
  logic [WIDTH-1:0]       m_q [NUM_FIFOS][$];
  logic [SEL_W+WIDTH-1:0] exp_q [$];
  logic                   m_ovf = 1'b0, m_udf = 1'b0, m_vld = 1'b0;
  logic [WIDTH-1:0]       m_dout = '0;
  logic [SEL_W-1:0]       m_sel = '0;
  bit                     m_started = 1'b0;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int m_used();
    int s = 0;
    for (int c = 0; c < NUM_FIFOS; c++) s += m_q[c].size();
    return s;
  endfunction

  function automatic bit m_full(input int c);
    return (m_used() == DEPTH) || (QUOTA_ON && m_q[c].size() == QUOTA);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_FIFOS; c++) m_q[c].delete();
      exp_q.delete();
      m_ovf = 1'b0; m_udf = 1'b0; m_vld = 1'b0; m_dout = '0; m_sel = '0;
      m_started = 1'b1;
    end else if (m_started) begin
      bit push_ok, pop_ok;
      push_ok = push && (int'(push_sel) < NUM_FIFOS) && !m_full(int'(push_sel));
      pop_ok  = pop && (int'(pop_sel) < NUM_FIFOS) && (m_q[pop_sel].size() > 0);
      m_vld = pop_ok;
      if (pop_ok) begin
        m_dout = m_q[pop_sel].pop_front();
        m_sel  = pop_sel;
        exp_q.push_back({pop_sel, m_dout});
      end
      if (push_ok) m_q[push_sel].push_back(data_in);
      if (push && !push_ok) m_ovf = 1'b1;
      if (pop && !pop_ok)   m_udf = 1'b1;
    end
  end

  // scoreboard: every cycle, away from the active edge
  always @(negedge clk) begin
    if (m_started) begin
      logic [NUM_FIFOS-1:0]       e_full, e_empty;
      logic [NUM_FIFOS*CNT_W-1:0] e_cnt;
      logic [SEL_W+WIDTH-1:0]     e;
      for (int c = 0; c < NUM_FIFOS; c++) begin
        e_full[c]               = m_full(c);
        e_empty[c]              = (m_q[c].size() == 0);
        e_cnt[c*CNT_W +: CNT_W] = CNT_W'(m_q[c].size());
      end
      check("full", 32'(full), 32'(e_full));
      check("empty", 32'(empty), 32'(e_empty));
      check("count", 32'(count), 32'(e_cnt));
      check("free_count", 32'(free_count), 32'(DEPTH - m_used()));
      check("ovf", 32'(ovf), 32'(m_ovf));
      check("udf", 32'(udf), 32'(m_udf));
      check("vld", 32'(data_out_vld), 32'(m_vld));
      check("data_hold", 32'(data_out), 32'(m_dout));
      if (m_vld && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pop_data", 32'(data_out), 32'(e[WIDTH-1:0]));
        check("pop_sel", 32'(data_out_sel), 32'(e[SEL_W+WIDTH-1:WIDTH]));
      end
    end
  end

  // driver: inputs change at the falling edge, one call per clock
  task automatic cyc(input logic p, input int ps, input logic [WIDTH-1:0] d,
                     input logic po, input int pos);
    push = p; push_sel = SEL_W'(ps); data_in = d;
    pop = po; pop_sel = SEL_W'(pos);
    @(negedge clk);
  endtask

  function automatic int cnt_of(input int c);
    return int'(count[c*CNT_W +: CNT_W]);
  endfunction

  initial begin
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    rst = 1'b0;
    check("rst_free", 32'(free_count), 32'd8);
    check("rst_empty", 32'(empty), 32'hF);
    check("rst_full", 32'(full), 32'h0);
    check("rst_vld", 32'(data_out_vld), 32'd0);

    // two entries through ch1
    cyc(1, 1, 8'hA1, 0, 0);
    cyc(1, 1, 8'hA2, 0, 0);
    cyc(0, 0, 0, 1, 1);
    check("t1_d0", 32'(data_out), 32'hA1);
    check("t1_sel", 32'(data_out_sel), 32'd1);
    cyc(0, 0, 0, 1, 1);
    check("t1_d1", 32'(data_out), 32'hA2);
    check("t1_vld", 32'(data_out_vld), 32'd1);
    cyc(0, 0, 0, 0, 0);
    check("t1_cnt1", 32'(cnt_of(1)), 32'd0);
    check("t1_free", 32'(free_count), 32'd8);

    // interleaved channels keep their own order
    cyc(1, 0, 8'h10, 0, 0);
    cyc(1, 2, 8'h20, 0, 0);
    cyc(1, 0, 8'h11, 0, 0);
    cyc(0, 0, 0, 1, 0);
    check("t2_d0", 32'(data_out), 32'h10);
    cyc(0, 0, 0, 1, 2);
    check("t2_d1", 32'(data_out), 32'h20);
    cyc(0, 0, 0, 1, 0);
    check("t2_d2", 32'(data_out), 32'h11);

    if (!QUOTA_ON) begin
      for (int i = 0; i < 8; i++) cyc(1, 3, 8'(8'hC0 + i), 0, 0);
      check("t3_full", 32'(full), 32'hF);
      check("t3_free0", 32'(free_count), 32'd0);
      cyc(1, 3, 8'hEE, 0, 0);
      check("t3_ovf", 32'(ovf), 32'd1);
      check("t3_cnt3", 32'(cnt_of(3)), 32'd8);
      cyc(1, 3, 8'hEF, 1, 3);
      check("t3_pp_data", 32'(data_out), 32'hC0);
      for (int i = 0; i < 7; i++) cyc(0, 0, 0, 1, 3);
      check("t3_last", 32'(data_out), 32'hC7);
    end else begin
      for (int i = 0; i < 4; i++) cyc(1, 0, 8'(8'h30 + i), 0, 0);
      check("q_full0", 32'(full[0]), 32'd1);
      check("q_full1", 32'(full[1]), 32'd0);
      cyc(1, 0, 8'h34, 0, 0);
      check("q_ovf", 32'(ovf), 32'd1);
      cyc(1, 1, 8'h40, 0, 0);
      check("q_cnt1", 32'(cnt_of(1)), 32'd1);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0);
      check("q_last", 32'(data_out), 32'h33);
      cyc(0, 0, 0, 1, 1);
      check("q_ch1", 32'(data_out), 32'h40);
    end

    // same-channel push and pop with a single resident entry
    cyc(1, 2, 8'h55, 0, 0);
    cyc(1, 2, 8'h66, 1, 2);
    check("t4_d0", 32'(data_out), 32'h55);
    check("t4_cnt2", 32'(cnt_of(2)), 32'd1);
    cyc(0, 0, 0, 1, 2);
    check("t4_d1", 32'(data_out), 32'h66);

    // underflow
    cyc(0, 0, 0, 1, 1);
    check("t5_udf", 32'(udf), 32'd1);
    check("t5_vld", 32'(data_out_vld), 32'd0);

    // random traffic with a reset in the middle
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) rst = 1'b1;
      cyc($urandom_range(0, 9) < 6, $urandom_range(0, NUM_FIFOS - 1), 8'($urandom_range(0, 255)),
          $urandom_range(0, 9) < 5, $urandom_range(0, NUM_FIFOS - 1));
      if (i == 700) begin
        rst = 1'b0;
        check("rst_cnt", 32'(count), 32'd0);
        check("rst_free2", 32'(free_count), 32'd8);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_udf", 32'(udf), 32'd0);
        check("rst_vld2", 32'(data_out_vld), 32'd0);
      end
    end
    cyc(0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
